interrupt_unit: RTL

INTERRUPT_UNIT -- requirements
Module: interrupt_unit

---
 rtl/interrupt_unit.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/interrupt_unit.sv
// Interrupt unit: synchronizes NSRC raw interrupt lines, keeps per-source
// pending state (edge or level mode), arbitrates the lowest-index enabled
// pending source and runs a request/acknowledge/end-of-interrupt handshake
// with the CPU. Software reaches four registers through a small bus port.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   src[NSRC-1:0]     raw interrupt lines (asynchronous to clk)
//   irq, icause[3:0]  request and cause code to the CPU
//   iack              one-cycle CPU acknowledge
//   cs, a, d, we, rd  register access (a[3:2] selects the register)
//   spo, ready        read data (valid only while ready=1), access-complete strobe
//
// Register map: 0x0 ENABLE, 0x4 PENDING (W1C), 0x8 EDGE, 0xC CAUSE (write = EOI).
module interrupt_unit #(
  parameter int unsigned NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  output logic            irq,
  output logic [3:0]      icause,
  input  logic            iack,
  input  logic            cs,
  input  logic [3:0]      a,
  input  logic [31:0]     d,
  input  logic            we,
  input  logic            rd,
  output logic [31:0]     spo,
  output logic            ready
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  // Synchronizer (s1, s2) plus the edge-detect history flop (s3).
  logic [NSRC-1:0] s1_q, s2_q, s3_q;
  logic [NSRC-1:0] enable_q, enable_d;
  logic [NSRC-1:0] edge_q, edge_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic            ready_q, ready_d;
  logic [31:0]     spo_q, spo_d;
  state_e          state_q, state_d;
  logic            irq_q, irq_d;
  logic [3:0]      icause_q, icause_d;
  logic            insvc_q, insvc_d;

  logic            access, wr;
  logic [1:0]      sel;
  logic            eoi;
  logic [NSRC-1:0] rise, w1c, active;
  logic [3:0]      low_idx;
  logic            cur_active;
  logic [31:0]     rdata;

  // Address bits [1:0] and data bits above NSRC-1 are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{a[1:0], d[31:NSRC]};

  assign access = cs & (rd | we);
  assign wr     = cs & we;
  assign sel    = a[3:2];
  assign eoi    = wr && (sel == 2'd3);
  assign rise   = s2_q & ~s3_q;
  assign w1c    = (wr && (sel == 2'd1)) ? d[NSRC-1:0] : '0;
  assign active = pend_q & enable_q;

  // Register writes.
  always_comb begin
    enable_d = enable_q;
    edge_d   = edge_q;
    if (wr && (sel == 2'd0)) enable_d = d[NSRC-1:0];
    if (wr && (sel == 2'd2)) edge_d   = d[NSRC-1:0];
  end

  // Pending update: level mode tracks the synchronized line; edge mode is
  // sticky, and a new rising edge beats a simultaneous W1C or acknowledge.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (edge_q[i]) begin
        if (w1c[i] || (state_q == StReq && iack && icause_q == 4'(i))) pend_d[i] = 1'b0;
        if (rise[i]) pend_d[i] = 1'b1;
      end else begin
        pend_d[i] = s2_q[i];
      end
    end
  end

  // Lowest-index active source, and whether the latched cause is still active.
  always_comb begin
    low_idx    = '0;
    cur_active = 1'b0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (active[i]) low_idx = 4'(i);
    end
    for (int i = 0; i < int'(NSRC); i++) begin
      if (icause_q == 4'(i)) cur_active = active[i];
    end
  end

  // Read mux. With rd and we together, the value held before the write is returned.
  always_comb begin
    rdata = '0;
    unique case (sel)
      2'd0: rdata = 32'(enable_q);
      2'd1: rdata = 32'(pend_q);
      2'd2: rdata = 32'(edge_q);
      2'd3: rdata = {27'b0, insvc_q, icause_q};
      default: rdata = '0;
    endcase
  end

  always_comb begin
    ready_d = access;
    spo_d   = (access && rd) ? rdata : '0;
  end

  // Request handshake.
  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    icause_d = icause_q;
    insvc_d  = insvc_q;
    unique case (state_q)
      StIdle: begin
        if (|active) begin
          state_d  = StReq;
          irq_d    = 1'b1;
          icause_d = low_idx;
        end
      end
      StReq: begin
        if (iack) begin
          state_d = StService;
          irq_d   = 1'b0;
          insvc_d = 1'b1;
        end else if (!cur_active) begin
          // Withdrawn request: the latched source lost its pending or enable.
          state_d  = StIdle;
          irq_d    = 1'b0;
          icause_d = '0;
        end
      end
      StService: begin
        if (eoi) begin
          state_d  = StIdle;
          insvc_d  = 1'b0;
          icause_d = '0;
        end
      end
      default: begin
        state_d  = StIdle;
        irq_d    = 1'b0;
        icause_d = '0;
        insvc_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      enable_q <= '0;
      edge_q   <= '0;
      pend_q   <= '0;
      ready_q  <= 1'b0;
      spo_q    <= '0;
      state_q  <= StIdle;
      irq_q    <= 1'b0;
      icause_q <= '0;
      insvc_q  <= 1'b0;
    end else begin
      s1_q     <= src;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      enable_q <= enable_d;
      edge_q   <= edge_d;
      pend_q   <= pend_d;
      ready_q  <= ready_d;
      spo_q    <= spo_d;
      state_q  <= state_d;
      irq_q    <= irq_d;
      icause_q <= icause_d;
      insvc_q  <= insvc_d;
    end
  end

  assign irq    = irq_q;
  assign icause = icause_q;
  assign ready  = ready_q;
  assign spo    = spo_q;

endmodule
